dekatron_step_sequencer: RTL and testbench

Drives the Step/En/Reverse inputs of a chain of DIGITS `Dekatron` counter stages, turning a single increment/decrement request into a timed sequence of per-digit step pulses with ripple carry/borrow. Sits directly upstream of the Dekatron chain. It reads back each stage's one-hot `Out` to decide whether the step wraps and must propagate. Clock-domain logic only; the Dekatron stages are clocked by the `Step` pulses this block generates.

---
 rtl/dekatron_step_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_dekatron_step_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dekatron_step_sequencer.sv
// dekatron_step_sequencer
// Turns a single +1/-1 request into a timed train of per-digit Step pulses
// for a chain of Dekatron decade stages, rippling carry/borrow upward by
// reading each stage's one-hot Out before it is stepped.
//
// Optional build macro: DEKATRON_SATURATE_EN
//   defined   -> a request that would wrap the whole chain is refused
//                (Done+Overflow next clock, no pulses, count unchanged)
//   undefined -> the chain wraps modulo 10^DIGITS and Overflow flags it
module dekatron_step_sequencer #(
  parameter int DIGITS        = 3,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Request,
  input  logic                   Dec,
  input  logic [DIGITS*10-1:0]   DigitIn,
  output logic [DIGITS-1:0]      Step,
  output logic [DIGITS-1:0]      En,
  output logic                   Reverse,
  output logic                   Ready,
  output logic                   Done,
  output logic                   Overflow
);

  localparam int KW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAXC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    SETTLE,
    DONE
  } state_t;

  state_t              state_q;
  logic [KW-1:0]       digitIdx_q;
  logic [CW-1:0]       cycleCnt_q;
  logic                wrap_q;
  logic [DIGITS-1:0]   step_q;
  logic [DIGITS-1:0]   en_q;
  logic                reverse_q;
  logic                ready_q;
  logic                done_q;
  logic                overflow_q;

  logic [DIGITS-1:0]   topBit;
  logic [DIGITS-1:0]   botBit;
  logic                wrapNow;
  logic                wrapNext;
  logic [DIGITS-1:0]   hotNow;
  logic [DIGITS-1:0]   hotNext;
  logic                lastDigit;
  logic                unusedMidBits;

  // Digit values 1..8 never steer the sequence; folding the whole bus keeps it visibly consumed
  assign unusedMidBits = ^DigitIn;

  // Pull the "about to wrap" candidates (value 9 going up, value 0 going down) out of each digit
  always_comb begin
    topBit = '0;
    botBit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      topBit[i] = DigitIn[10*i + 9];
      botBit[i] = DigitIn[10*i];
    end
  end

  // Wrap flag and one-hot select for the current digit and the one a carry would move to
  always_comb begin
    wrapNow  = 1'b0;
    wrapNext = 1'b0;
    hotNow   = '0;
    hotNext  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == int'(digitIdx_q)) begin
        wrapNow   = reverse_q ? botBit[i] : topBit[i];
        hotNow[i] = 1'b1;
      end
      if (i == int'(digitIdx_q) + 1) begin
        wrapNext   = reverse_q ? botBit[i] : topBit[i];
        hotNext[i] = 1'b1;
      end
    end
    lastDigit = (int'(digitIdx_q) == DIGITS - 1);
  end

  // Sequencer: state, digit index, phase counter and all registered outputs
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      digitIdx_q <= '0;
      cycleCnt_q <= '0;
      wrap_q     <= 1'b0;
      step_q     <= '0;
      en_q       <= '0;
      reverse_q  <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Request) begin
            reverse_q  <= Dec;
            digitIdx_q <= '0;
            cycleCnt_q <= '0;
            ready_q    <= 1'b0;
`ifdef DEKATRON_SATURATE_EN
            if (Dec ? (&botBit) : (&topBit)) begin
              done_q     <= 1'b1;
              overflow_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              state_q    <= SETUP;
            end
`else
            state_q    <= SETUP;
`endif
          end
        end
        SETUP: begin
          wrap_q     <= wrapNow;
          step_q     <= hotNow;
          en_q       <= hotNow;
          cycleCnt_q <= '0;
          state_q    <= PULSE;
        end
        PULSE: begin
          if (cycleCnt_q == CW'(PULSE_CYCLES - 1)) begin
            step_q     <= '0;
            cycleCnt_q <= '0;
            state_q    <= SETTLE;
          end else begin
            cycleCnt_q <= cycleCnt_q + 1'b1;
          end
        end
        SETTLE: begin
          if (cycleCnt_q == CW'(SETTLE_CYCLES - 1)) begin
            cycleCnt_q <= '0;
            if (wrap_q && !lastDigit) begin
              digitIdx_q <= digitIdx_q + 1'b1;
              wrap_q     <= wrapNext;
              step_q     <= hotNext;
              en_q       <= hotNext;
              state_q    <= PULSE;
            end else begin
              en_q       <= '0;
              done_q     <= 1'b1;
              overflow_q <= wrap_q && lastDigit;
              state_q    <= DONE;
            end
          end else begin
            cycleCnt_q <= cycleCnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q     <= 1'b0;
          overflow_q <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Step     = step_q;
  assign En       = en_q;
  assign Reverse  = reverse_q;
  assign Ready    = ready_q;
  assign Done     = done_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// tb_dekatron_step_sequencer
// Drives the sequencer against a behavioural model of a 3-stage Dekatron
// chain and compares every operation with an arithmetic reference.
module tb_dekatron_step_sequencer;

  localparam int DIGITS        = 3;
  localparam int PULSE_CYCLES  = 2;
  localparam int SETTLE_CYCLES = 3;
  localparam int MODULUS       = 1000;
  localparam int PERIOD        = PULSE_CYCLES + SETTLE_CYCLES;
  localparam int BASE_LAT      = 1 + PULSE_CYCLES + SETTLE_CYCLES + 1;

  logic                  Clk     = 1'b0;
  logic                  Rst_n   = 1'b0;
  logic                  Request = 1'b0;
  logic                  Dec     = 1'b0;
  logic [DIGITS*10-1:0]  DigitIn;
  logic [DIGITS-1:0]     Step;
  logic [DIGITS-1:0]     En;
  logic                  Reverse;
  logic                  Ready;
  logic                  Done;
  logic                  Overflow;

  int vecCount  = 0;
  int missCount = 0;
  int cyc       = 0;
  int digitVal [DIGITS] = '{default: 0};
  logic [DIGITS-1:0] prevStep = '0;
  int riseCyc[$];
  int riseDigit[$];
  int highCount = 0;

  dekatron_step_sequencer #(
    .DIGITS        (DIGITS),
    .PULSE_CYCLES  (PULSE_CYCLES),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Request  (Request),
    .Dec      (Dec),
    .DigitIn  (DigitIn),
    .Step     (Step),
    .En       (En),
    .Reverse  (Reverse),
    .Ready    (Ready),
    .Done     (Done),
    .Overflow (Overflow)
  );

  // Free-running clock and cycle counter
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // One-hot Out of every modelled stage
  always_comb begin
    DigitIn = '0;
    for (int i = 0; i < DIGITS; i++) DigitIn[10*i + digitVal[i]] = 1'b1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Dekatron chain model: a stage advances on the rising edge of its Step while enabled
  always @(negedge Clk) begin
    for (int i = 0; i < DIGITS; i++) begin
      if (Step[i] && !prevStep[i]) begin
        if (En[i]) digitVal[i] = Reverse ? (digitVal[i] + 9) % 10 : (digitVal[i] + 1) % 10;
        riseCyc.push_back(cyc);
        riseDigit.push_back(i);
      end
    end
    highCount += $countones(Step);
    if (Step != '0) begin
      checkOutput("oneStepHigh", $countones(Step), 1);
      checkOutput("enWithStep", int'(En & Step), int'(Step));
    end
    prevStep = Step;
  end

  function automatic int countValue();
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + digitVal[i];
    return v;
  endfunction

  task automatic setCount(input int v);
    int t;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      digitVal[i] = t % 10;
      t = t / 10;
    end
  endtask

  // Reference: decimal +/-1 with carry count derived from trailing 9s/0s
  function automatic void refStep(input int v, input bit dn, output int nv,
                                  output int pulses, output bit ovf);
    int t;
    t = v;
    pulses = 1;
    while (pulses < DIGITS && (t % 10) == (dn ? 0 : 9)) begin
      pulses++;
      t = t / 10;
    end
    nv  = dn ? (v + MODULUS - 1) % MODULUS : (v + 1) % MODULUS;
    ovf = dn ? (v == 0) : (v == MODULUS - 1);
  endfunction

  task automatic waitReady();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (Ready) begin
        seen = 1'b1;
        break;
      end
      @(posedge Clk); #1;
    end
    if (!seen) checkOutput("readyTimeout", 0, 1);
  endtask

  // One full count operation checked against the reference
  task automatic applyStimulus(input bit dn);
    int  startV, expV, pulses, drv, nChk;
    bit  ovf, gotDone;
    waitReady();
    startV = countValue();
    refStep(startV, dn, expV, pulses, ovf);
    riseCyc.delete();
    riseDigit.delete();
    highCount = 0;
    Request = 1'b1;
    Dec     = dn;
    drv     = cyc;
    @(posedge Clk); #1;
    Request = 1'b0;
    checkOutput("readyLowBusy", Ready, 0);
    gotDone = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (Done) begin
        gotDone = 1'b1;
        break;
      end
      @(posedge Clk); #1;
    end
    if (!gotDone) begin
      checkOutput("doneTimeout", 0, 1);
      return;
    end
    checkOutput("latency", cyc - drv, BASE_LAT + PERIOD * (pulses - 1));
    checkOutput("overflow", Overflow, ovf);
    checkOutput("reverseHeld", Reverse, dn);
    checkOutput("pulseCount", riseCyc.size(), pulses);
    nChk = (riseCyc.size() < pulses) ? riseCyc.size() : pulses;
    for (int i = 0; i < nChk; i++) begin
      checkOutput("stepDigit", riseDigit[i], i);
      checkOutput("stepRiseTime", riseCyc[i] - drv, 2 + PERIOD * i);
    end
    checkOutput("stepWidth", highCount, pulses * PULSE_CYCLES);
    @(posedge Clk); #1;
    checkOutput("doneWidth", Done, 0);
    checkOutput("overflowWidth", Overflow, 0);
    checkOutput("readyAfterDone", Ready, 1);
    checkOutput("countAfter", countValue(), expV);
  endtask

  initial begin
    int  v, nv, p, n, acc, readyCnt, doneHigh, doneRise, found, doneSeen, sel;
    bit  o, prevDone, dn;

    // Reset values
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rstStep", Step, 0);
    checkOutput("rstEn", En, 0);
    checkOutput("rstReverse", Reverse, 0);
    checkOutput("rstReady", Ready, 1);
    checkOutput("rstDone", Done, 0);
    checkOutput("rstOverflow", Overflow, 0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Directed corners: plain increment, single carry, full wrap, full borrow
    setCount(0);   applyStimulus(1'b0);
    setCount(9);   applyStimulus(1'b0);
    setCount(999); applyStimulus(1'b0);
    setCount(100); applyStimulus(1'b1);
    setCount(0);   applyStimulus(1'b1);

    // Request held high for 20 clocks: one operation per IDLE visit
    waitReady();
    setCount(0);
    v = 0; n = 0; acc = 0;
    while (n + 1 <= 20) begin
      acc++;
      refStep(v, 1'b0, nv, p, o);
      n += BASE_LAT + PERIOD * (p - 1) + 1;
      v = nv;
    end
    Request = 1'b1;
    Dec = 1'b0;
    readyCnt = 0; doneHigh = 0; doneRise = 0; prevDone = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k < 20 && Ready) readyCnt++;
      if (Done) doneHigh++;
      if (Done && !prevDone) doneRise++;
      prevDone = Done;
      @(posedge Clk); #1;
      if (k == 19) Request = 1'b0;
    end
    checkOutput("holdAccepts", doneRise, acc);
    checkOutput("holdDoneWidth", doneHigh, doneRise);
    checkOutput("holdReadyIdle", readyCnt, acc);
    checkOutput("holdCount", countValue(), v);

    // Reset during the second pulse of a carry chain
    waitReady();
    setCount(9);
    Request = 1'b1;
    Dec = 1'b0;
    @(posedge Clk); #1;
    Request = 1'b0;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (Step[1]) begin
        found = 1;
        break;
      end
      @(posedge Clk); #1;
    end
    checkOutput("midResetReached", found, 1);
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    checkOutput("midRstStep", Step, 0);
    checkOutput("midRstEn", En, 0);
    checkOutput("midRstReady", Ready, 1);
    checkOutput("midRstDone", Done, 0);
    Rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge Clk); #1;
      if (Done) doneSeen++;
    end
    checkOutput("midRstNoDone", doneSeen, 0);
    checkOutput("midRstPartial", countValue(), 10);

    // Randomized operations from interesting and random starting counts
    for (int it = 0; it < 30; it++) begin
      waitReady();
      sel = $urandom_range(0, 6);
      case (sel)
        0: setCount(0);
        1: setCount(9);
        2: setCount(99);
        3: setCount(999);
        4: setCount(100);
        5: setCount($urandom_range(0, MODULUS - 1));
        default: ;
      endcase
      dn = 1'($urandom_range(0, 1));
      applyStimulus(dn);
      repeat ($urandom_range(0, 3)) begin
        @(posedge Clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
